// File: rtl/i2c_ram_arbiter_pkg.sv
// Shared types, encodings and helpers for the I2C RAM-port arbiter.
package i2c_ram_arbiter_pkg;

  localparam int unsigned RAM_ADDR_W = 5;
  localparam int unsigned RAM_DATA_W = 8;
  localparam int unsigned AGE_W      = 4;

  localparam logic I2C_MODE_MASTER = 1'b0;
  localparam logic I2C_MODE_SLAVE  = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_SLV  = 2'd1,
    OWN_MST  = 2'd2,
    OWN_MENU = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_HANDOVER = 2'd2
  } state_e;

  // Pick a winner from {menu,mst,slv}; aged requesters beat non-aged ones,
  // and within either group slv > mst > menu.
  function automatic owner_e arb_pick(input logic [2:0] elig, input logic [2:0] aged);
    logic [2:0] cand;
    owner_e     win;
    if ((elig & aged) != 3'b000) begin
      cand = elig & aged;
    end else begin
      cand = elig;
    end
    if (cand[0]) begin
      win = OWN_SLV;
    end else if (cand[1]) begin
      win = OWN_MST;
    end else if (cand[2]) begin
      win = OWN_MENU;
    end else begin
      win = OWN_NONE;
    end
    return win;
  endfunction

  // One-hot grant vector {menu,mst,slv} for an owner encoding.
  function automatic logic [2:0] owner_to_gnt(input owner_e own);
    logic [2:0] g;
    case (own)
      OWN_SLV:  g = 3'b001;
      OWN_MST:  g = 3'b010;
      OWN_MENU: g = 3'b100;
      default:  g = 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/i2c_ram_arbiter_if.sv
// Requester / RAM-port / mode-control bundle of the I2C RAM arbiter.
interface i2c_ram_arbiter_if;
  import i2c_ram_arbiter_pkg::*;

  logic                  slv_req;
  logic                  mst_req;
  logic                  menu_req;
  logic [RAM_ADDR_W-1:0] slv_add;
  logic [RAM_ADDR_W-1:0] mst_add;
  logic [RAM_ADDR_W-1:0] menu_add;
  logic [RAM_DATA_W-1:0] slv_din;
  logic [RAM_DATA_W-1:0] mst_din;
  logic [RAM_DATA_W-1:0] menu_din;
  logic                  slv_w;
  logic                  mst_w;
  logic                  menu_w;
  logic [2:0]            gnt;
  logic [RAM_ADDR_W-1:0] RAM_ADD;
  logic [RAM_DATA_W-1:0] RAM_DIN;
  logic                  RAM_W;
  logic                  mode_req;
  logic                  mode_sel;
  logic                  i2c_mode;
  logic                  mode_done;
  logic                  viol;

  // Arbiter side.
  modport slave (
    input  slv_req, mst_req, menu_req,
    input  slv_add, mst_add, menu_add,
    input  slv_din, mst_din, menu_din,
    input  slv_w, mst_w, menu_w,
    input  mode_req, mode_sel,
    output gnt, RAM_ADD, RAM_DIN, RAM_W,
    output i2c_mode, mode_done, viol
  );

  // Requester / environment side.
  modport master (
    output slv_req, mst_req, menu_req,
    output slv_add, mst_add, menu_add,
    output slv_din, mst_din, menu_din,
    output slv_w, mst_w, menu_w,
    output mode_req, mode_sel,
    input  gnt, RAM_ADD, RAM_DIN, RAM_W,
    input  i2c_mode, mode_done, viol
  );

endinterface

// File: rtl/i2c_ram_arbiter_age_counter.sv
// Per-requester starvation counter: counts waiting cycles, saturates at the limit.
module i2c_arb_age_counter
  import i2c_ram_arbiter_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic eligible_i,
  input  logic granted_i,
  output logic aged_o
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_LIMIT);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;

  // Next age: clear when not waiting or once served, else count up to the limit.
  always_comb begin
    age_d = age_q;
    if (!eligible_i || granted_i) begin
      age_d = {AGE_W{1'b0}};
    end else if (age_q < LIMIT) begin
      age_d = age_q + 4'd1;
    end else begin
      age_d = age_q;
    end
  end

  // Age register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= {AGE_W{1'b0}};
    end else begin
      age_q <= age_d;
    end
  end

  assign aged_o = (age_q >= LIMIT);

endmodule

// File: rtl/i2c_ram_arbiter.sv
// Arbitrates the shared RAM port between the slave engine, master controller
// and menu RAM-clear logic, and sequences I2C master/slave mode switches so
// that they only take effect while the port is idle.
module i2c_ram_arbiter #(
  parameter int unsigned AGE_LIMIT = 15
) (
  input  logic               clk,
  input  logic               reset,
  i2c_ram_arbiter_if.slave   bus
);
  import i2c_ram_arbiter_pkg::*;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [2:0]            gnt_q, gnt_d;
  logic                  i2c_mode_q, i2c_mode_d;
  logic                  pend_q, pend_d;
  logic                  pend_val_q, pend_val_d;
  logic                  mode_done_q, mode_done_d;
  logic                  viol_q, viol_d;

  logic [2:0]            elig_s;
  logic [2:0]            aged_s;
  logic [2:0]            w_vec_s;
  owner_e                win_s;
  logic                  own_req_s;
  logic                  own_w_s;
  logic                  own_gnt_s;
  logic [RAM_ADDR_W-1:0] own_add_s;
  logic [RAM_DATA_W-1:0] own_din_s;

  // A requester only competes when the current I2C mode allows it to touch the RAM.
  assign elig_s  = {bus.menu_req,
                    bus.mst_req & (i2c_mode_q == I2C_MODE_MASTER),
                    bus.slv_req & (i2c_mode_q == I2C_MODE_SLAVE)};
  assign w_vec_s = {bus.menu_w, bus.mst_w, bus.slv_w};

  i2c_arb_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_slv (
    .clk        (clk),
    .reset      (reset),
    .eligible_i (elig_s[0]),
    .granted_i  (gnt_q[0]),
    .aged_o     (aged_s[0])
  );

  i2c_arb_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_mst (
    .clk        (clk),
    .reset      (reset),
    .eligible_i (elig_s[1]),
    .granted_i  (gnt_q[1]),
    .aged_o     (aged_s[1])
  );

  i2c_arb_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_menu (
    .clk        (clk),
    .reset      (reset),
    .eligible_i (elig_s[2]),
    .granted_i  (gnt_q[2]),
    .aged_o     (aged_s[2])
  );

  // Route the current owner's request, strobe and bus onto the shared RAM port.
  always_comb begin
    own_req_s = 1'b0;
    own_w_s   = 1'b0;
    own_gnt_s = 1'b0;
    own_add_s = {RAM_ADDR_W{1'b0}};
    own_din_s = {RAM_DATA_W{1'b0}};
    case (owner_q)
      OWN_SLV: begin
        own_req_s = bus.slv_req;
        own_w_s   = bus.slv_w;
        own_gnt_s = gnt_q[0];
        own_add_s = bus.slv_add;
        own_din_s = bus.slv_din;
      end
      OWN_MST: begin
        own_req_s = bus.mst_req;
        own_w_s   = bus.mst_w;
        own_gnt_s = gnt_q[1];
        own_add_s = bus.mst_add;
        own_din_s = bus.mst_din;
      end
      OWN_MENU: begin
        own_req_s = bus.menu_req;
        own_w_s   = bus.menu_w;
        own_gnt_s = gnt_q[2];
        own_add_s = bus.menu_add;
        own_din_s = bus.menu_din;
      end
      default: begin
        own_req_s = 1'b0;
        own_w_s   = 1'b0;
        own_gnt_s = 1'b0;
        own_add_s = {RAM_ADDR_W{1'b0}};
        own_din_s = {RAM_DATA_W{1'b0}};
      end
    endcase
  end

  // Arbitration FSM next state plus mode-switch sequencing.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    i2c_mode_d  = i2c_mode_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    mode_done_d = 1'b0;
    win_s       = arb_pick(elig_s, aged_s);

    // A new request always (re)loads the pending value; no extra done pulse.
    if (bus.mode_req) begin
      pend_d     = 1'b1;
      pend_val_d = bus.mode_sel;
    end else begin
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          // A same-cycle overwrite wins over the older pending value.
          i2c_mode_d  = bus.mode_req ? bus.mode_sel : pend_val_q;
          mode_done_d = 1'b1;
          pend_d      = 1'b0;
        end else if (!bus.mode_req && (elig_s != 3'b000)) begin
          // Grants are held off while a mode switch is about to be latched.
          owner_d = win_s;
          gnt_d   = owner_to_gnt(win_s);
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (own_req_s) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_HANDOVER;
          owner_d = OWN_NONE;
          gnt_d   = 3'b000;
        end
      end
      ST_HANDOVER: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        gnt_d   = 3'b000;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // Any strobe from a requester without a grant is dropped and flagged forever.
  assign viol_d = viol_q | ((w_vec_s & ~gnt_q) != 3'b000);

  // State, grant, mode and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      gnt_q       <= 3'b000;
      i2c_mode_q  <= I2C_MODE_MASTER;
      pend_q      <= 1'b0;
      pend_val_q  <= 1'b0;
      mode_done_q <= 1'b0;
      viol_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      i2c_mode_q  <= i2c_mode_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      mode_done_q <= mode_done_d;
      viol_q      <= viol_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.RAM_ADD   = own_add_s;
  assign bus.RAM_DIN   = own_din_s;
  assign bus.RAM_W     = own_w_s & own_gnt_s;
  assign bus.i2c_mode  = i2c_mode_q;
  assign bus.mode_done = mode_done_q;
  assign bus.viol      = viol_q;

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// Scoreboard bench for i2c_ram_arbiter: each cycle the stimulus pushes the
// expected port values, and they are popped and compared after the clock edge.
module tb_i2c_ram_arbiter;
  import i2c_ram_arbiter_pkg::*;

  typedef struct packed {
    logic [2:0] gnt;
    logic       ram_w;
    logic [4:0] add;
    logic [7:0] din;
    logic       mode;
    logic       done;
    logic       viol;
  } exp_t;

  logic  clk;
  logic  reset;
  exp_t  exp_q[$];
  string tag_q[$];
  int    checks_n;
  int    errors_n;

  // Expected state tracked by the scenarios.
  logic [2:0] e_gnt;
  logic       e_mode;
  logic       e_done;
  logic       e_viol;

  i2c_ram_arbiter_if bus();

  i2c_ram_arbiter #(.AGE_LIMIT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_n = checks_n + 1;
    if (act !== exp) begin
      errors_n = errors_n + 1;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Build the expectation: the RAM port follows whichever requester holds the grant.
  task automatic push_exp(input string tag);
    exp_t e;
    e.gnt  = e_gnt;
    e.mode = e_mode;
    e.done = e_done;
    e.viol = e_viol;
    case (e_gnt)
      3'b001: begin e.add = bus.slv_add;  e.din = bus.slv_din;  e.ram_w = bus.slv_w;  end
      3'b010: begin e.add = bus.mst_add;  e.din = bus.mst_din;  e.ram_w = bus.mst_w;  end
      3'b100: begin e.add = bus.menu_add; e.din = bus.menu_din; e.ram_w = bus.menu_w; end
      default: begin e.add = 5'h00; e.din = 8'h00; e.ram_w = 1'b0; end
    endcase
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq({t, "_gnt"},  32'(bus.gnt),       32'(e.gnt));
      check_eq({t, "_w"},    32'(bus.RAM_W),     32'(e.ram_w));
      check_eq({t, "_add"},  32'(bus.RAM_ADD),   32'(e.add));
      check_eq({t, "_din"},  32'(bus.RAM_DIN),   32'(e.din));
      check_eq({t, "_mode"}, 32'(bus.i2c_mode),  32'(e.mode));
      check_eq({t, "_done"}, 32'(bus.mode_done), 32'(e.done));
      check_eq({t, "_viol"}, 32'(bus.viol),      32'(e.viol));
    end
  endtask

  // One clock: push expectation, let the edge happen, compare, return on negedge.
  task automatic step(input string tag);
    push_exp(tag);
    @(posedge clk);
    #2;
    pop_check();
    @(negedge clk);
  endtask

  initial begin
    checks_n = 0;
    errors_n = 0;
    e_gnt = 3'b000; e_mode = 1'b0; e_done = 1'b0; e_viol = 1'b0;
    bus.slv_req = 1'b0; bus.mst_req = 1'b0; bus.menu_req = 1'b0;
    bus.slv_w = 1'b0;   bus.mst_w = 1'b0;   bus.menu_w = 1'b0;
    bus.slv_add = 5'h03;  bus.slv_din = 8'h5A;
    bus.mst_add = 5'h0A;  bus.mst_din = 8'h3C;
    bus.menu_add = 5'h11; bus.menu_din = 8'h77;
    bus.mode_req = 1'b0; bus.mode_sel = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    @(negedge clk);
    step("rst0");
    step("rst1");
    reset = 1'b1;
    step("rst_rel");

    // mst beats menu; menu follows after HANDOVER and an idle arbitration cycle.
    bus.mst_req = 1'b1; bus.menu_req = 1'b1;
    e_gnt = 3'b010; step("A_mst_gnt");
    bus.mst_w = 1'b1; step("A_mst_wr");
    bus.mst_w = 1'b0; bus.mst_req = 1'b0;
    e_gnt = 3'b000; step("A_handover");
    step("A_idle");
    e_gnt = 3'b100; step("A_menu_gnt");
    bus.menu_req = 1'b0;
    e_gnt = 3'b000; step("A_menu_rel");
    step("A_idle2");

    // slv is ignored in master mode until the switch to slave mode.
    bus.slv_req = 1'b1;
    step("B_slv_ign0");
    step("B_slv_ign1");
    step("B_slv_ign2");
    check_eq("B_slv_age", 32'(dut.u_age_slv.age_q), 32'd0);
    bus.mode_req = 1'b1; bus.mode_sel = 1'b1;
    step("B_mode_req");
    bus.mode_req = 1'b0;
    e_mode = 1'b1; e_done = 1'b1; step("B_switch");
    e_done = 1'b0; e_gnt = 3'b001; step("B_slv_gnt");

    // Mode requests during a grant: overwrite, no new grant until switched.
    bus.mode_req = 1'b1; bus.mode_sel = 1'b1; step("C_req1");
    bus.mode_sel = 1'b0; step("C_req2");
    bus.mode_req = 1'b0; bus.menu_req = 1'b1; step("C_hold");
    bus.slv_req = 1'b0;
    e_gnt = 3'b000; step("C_handover");
    step("C_idle");
    e_mode = 1'b0; e_done = 1'b1; step("C_switch");
    e_done = 1'b0; e_gnt = 3'b100; step("C_menu_gnt");
    bus.menu_req = 1'b0;
    e_gnt = 3'b000; step("C_rel");
    step("C_idle2");
    check_eq("C_done_cnt_mode", 32'(bus.i2c_mode), 32'd0);

    // menu starves under a long mst grant, then beats a fresh mst request.
    bus.mst_req = 1'b1; bus.menu_req = 1'b1;
    e_gnt = 3'b010; step("E_mst_gnt");
    for (int i = 0; i < 40; i++) step("E_hold");
    check_eq("E_menu_age", 32'(dut.u_age_menu.age_q), 32'd15);
    bus.mst_req = 1'b0;
    e_gnt = 3'b000; step("E_handover");
    bus.mst_req = 1'b1; step("E_idle");
    e_gnt = 3'b100; step("E_menu_wins");
    bus.menu_req = 1'b0;
    e_gnt = 3'b000; step("E_menu_rel");
    step("E_idle2");
    e_gnt = 3'b010; step("E_mst_gnt2");
    bus.mst_req = 1'b0;
    e_gnt = 3'b000; step("E_rel");
    step("E_idle3");

    // Write strobe from a non-owner is dropped and sets the sticky flag.
    bus.mst_req = 1'b1;
    e_gnt = 3'b010; step("D_mst_gnt");
    bus.menu_w = 1'b1;
    e_viol = 1'b1; step("D_viol");
    bus.menu_w = 1'b0; bus.mst_w = 1'b1; bus.mst_add = 5'h1F; bus.mst_din = 8'hA5;
    step("D_write");

    // Asynchronous reset in the middle of a write.
    e_gnt = 3'b000; e_viol = 1'b0; e_mode = 1'b0;
    push_exp("F_rst_now");
    reset = 1'b0;
    #1;
    pop_check();
    @(negedge clk);
    step("F_rst_hold");
    bus.mst_req = 1'b0; bus.mst_w = 1'b0;
    reset = 1'b1;
    step("F_rst_rel");
    bus.mst_req = 1'b1;
    e_gnt = 3'b010; step("F_regrant");

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
